// File: rtl/ks_64bit.sv
// 64-bit Kogge-Stone adder, registered sum and carry vector.
// Optional KS64_PIPELINE_EN adds a register stage after prefix level 3.
module ks_64bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [64:0] s,
    output logic [63:0] c,
    output logic        out_valid
);

    // One prefix level: G=Gh|(Ph&Gl), P=Ph&Pl; bits below span pass through.
    function automatic logic [127:0] ks_lvl(
        input logic [63:0] g,
        input logic [63:0] p,
        input int          span
    );
        logic [63:0] lo;
        logic [63:0] gn;
        logic [63:0] pn;
        lo = (64'd1 << span) - 64'd1;
        gn = g | (p & (g << span));
        pn = p & ((p << span) | lo);
        return {gn, pn};
    endfunction

    logic [63:0] p0;
    logic [63:0] g0;
    logic [63:0] g1, p1, g2, p2, g3, p3;
    logic [63:0] g4, p4, g5, p5, g6, p6;
    logic [63:0] gb, pb, pvb;
    logic        cinb;
    logic        vb;
    logic [64:0] s_nxt;

    // cin enters as the bit -1 generate, absorbed into bit 0
    always_comb begin
        p0    = a ^ b;
        g0    = a & b;
        g0[0] = (a[0] & b[0]) | (p0[0] & cin);
    end

    assign {g1, p1} = ks_lvl(g0, p0, 1);
    assign {g2, p2} = ks_lvl(g1, p1, 2);
    assign {g3, p3} = ks_lvl(g2, p2, 4);

`ifdef KS64_PIPELINE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gb   <= '0;
            pb   <= '0;
            pvb  <= '0;
            cinb <= 1'b0;
            vb   <= 1'b0;
        end else begin
            gb   <= g3;
            pb   <= p3;
            pvb  <= p0;
            cinb <= cin;
            vb   <= in_valid;
        end
    end
`else
    always_comb begin
        gb   = g3;
        pb   = p3;
        pvb  = p0;
        cinb = cin;
        vb   = in_valid;
    end
`endif

    assign {g4, p4} = ks_lvl(gb, pb, 8);
    assign {g5, p5} = ks_lvl(g4, p4, 16);
    assign {g6, p6} = ks_lvl(g5, p5, 32);

    assign s_nxt = {g6[63], pvb ^ {g6[62:0], cinb}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            c         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= vb;
            if (vb) begin
                s <= s_nxt;
                c <= g6;
            end
        end
    end

endmodule

// File: tb/tb_ks_64bit.sv
// Self-checking bench for ks_64bit: scoreboard of expected sum/carry,
// checked every cycle against a latency-aware valid history.
module tb_ks_64bit;

`ifdef KS64_PIPELINE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [64:0] s;
    logic [63:0] c;
    logic        out_valid;

    ks_64bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .s         (s),
        .c         (c),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [128:0] sb[$];
    logic [1:0]   vh = 2'b00;
    logic [64:0]  last_s = '0;
    logic [63:0]  last_c = '0;

    function automatic logic [128:0] model(
        input logic [63:0] x,
        input logic [63:0] y,
        input logic        ci
    );
        logic [64:0] sum;
        logic [63:0] t;
        sum = {1'b0, x} + {1'b0, y} + {64'd0, ci};
        // carry into bit i is x^y^sum at bit i
        t = x ^ y ^ sum[63:0];
        return {sum, sum[64], t[63:1]};
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs,
                       input logic [64:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] x,
                         input logic [63:0] y, input logic ci,
                         input logic [64:0] es, input logic [63:0] ec);
        logic         ev;
        logic [128:0] e;
        @(negedge clk);
        in_valid = v;
        a        = x;
        b        = y;
        cin      = ci;
        if (v) sb.push_back({es, ec});
        vh = {vh[0], v};
        @(posedge clk);
        #1;
        ev = (LAT == 2) ? vh[1] : vh[0];
        chk("out_valid", {64'd0, out_valid}, {64'd0, ev});
        if (ev && sb.size() > 0) begin
            e      = sb.pop_front();
            last_s = e[128:64];
            last_c = e[63:0];
        end
        chk("s", s, last_s);
        chk("c", {1'b0, c}, {1'b0, last_c});
    endtask

    task automatic op(input logic v, input logic [63:0] x,
                      input logic [63:0] y, input logic ci);
        logic [128:0] m;
        m = model(x, y, ci);
        drive(v, x, y, ci, m[128:64], m[63:0]);
    endtask

    initial begin
        logic [128:0] m;
        logic [63:0]  x;
        logic [63:0]  y;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_s", s, 65'd0);
        chk("rst_c", {1'b0, c}, 65'd0);
        chk("rst_v", {64'd0, out_valid}, 65'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed vectors, back to back right after reset release
        drive(1'b1, 64'h0, 64'h0, 1'b0, 65'h0, 64'h0);
        m = model(64'h631ff211631ff211, 64'h12356312faf2fcff, 1'b0);
        drive(1'b1, 64'h631ff211631ff211, 64'h12356312faf2fcff, 1'b0,
              65'h0_755555245E12EF10, m[63:0]);
        drive(1'b1, 64'hffffffffffffffff, 64'hffffffff11111111, 1'b0,
              65'h1_FFFFFFFF11111110, 64'hffffffffffffffff);
        drive(1'b1, 64'hffffffffffffffff, 64'h0, 1'b1,
              65'h1_0000000000000000, 64'hffffffffffffffff);
        repeat (3) op(1'b0, 64'h0, 64'h0, 1'b0);

        // four back-to-back distinct operands, then idle with held outputs
        for (int i = 0; i < 4; i++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            op(1'b1, x, y, 1'(i & 1));
        end
        repeat (3) op(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);

        // mixed valid pattern with edge operands
        op(1'b1, 64'h8000000000000000, 64'h8000000000000000, 1'b0);
        op(1'b0, 64'h1, 64'h1, 1'b1);
        op(1'b1, 64'h7fffffffffffffff, 64'h0, 1'b1);
        op(1'b1, 64'haaaaaaaaaaaaaaaa, 64'h5555555555555555, 1'b1);
        op(1'b0, 64'h0, 64'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            op(1'($urandom_range(0, 1)), x, y, 1'($urandom_range(0, 1)));
        end
        op(1'b1, 64'hdeadbeefcafef00d, 64'h0123456789abcdef, 1'b1);

        // reset pulsed while an operation is in flight
        @(negedge clk);
        in_valid = 1'b1;
        a        = 64'hffffffffffffffff;
        b        = 64'h1;
        cin      = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_s", s, 65'd0);
        chk("midrst_c", {1'b0, c}, 65'd0);
        chk("midrst_v", {64'd0, out_valid}, 65'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        vh     = 2'b00;
        last_s = '0;
        last_c = '0;
        repeat (3) op(1'b0, 64'h5, 64'h6, 1'b0);

        // normal operation resumes after the discarded work
        op(1'b1, 64'h0000000100000000, 64'h00000000ffffffff, 1'b1);
        repeat (LAT + 1) op(1'b0, 64'h0, 64'h0, 1'b0);
        chk("sb_drained", 65'(sb.size()), 65'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ks_64bit.md
KS_64BIT -- requirements
Module: ks_64bit

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 64 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operands/cin valid this cycle.
REQ-005 a  input  64  operand A.
REQ-006 b  input  64  operand B.
REQ-007 cin  input  1  carry-in to bit 0.
REQ-008 s  output  65  registered sum; s[64] is carry-out.
REQ-009 c  output  64  registered carry vector; c[i] is carry out of bit i.
REQ-010 out_valid  output  1  s/c hold the result of an accepted operation.

Function
REQ-011 Block SHALL compute {s} = a + b + cin, all unsigned, 65-bit result with no truncation.
REQ-012 Per bit, generate g[i]=a[i]&b[i] and propagate p[i]=a[i]^b[i]; cin SHALL be folded in as bit -1 generate.
REQ-013 Carries SHALL come from a radix-2 Kogge-Stone parallel-prefix tree, 6 levels, spans 1,2,4,8,16,32.
REQ-014 Each prefix node: G=Gh|(Ph&Gl), P=Ph&Pl; no ripple chains longer than one node.
REQ-015 c[i] SHALL equal the group generate over bits i..0 including cin.
REQ-016 s[i] = p[i]^c[i-1] for i>=1, s[0] = p[0]^cin, s[64] = c[63].
REQ-017 A cycle with in_valid=1 SHALL be accepted; result SHALL appear on s/c with out_valid=1 after the configured latency.
REQ-018 Accepted operations SHALL be fully pipelined: one new operation per cycle, back-to-back in_valid supported, no stall, no backpressure.
REQ-019 Cycles with in_valid=0 SHALL produce out_valid=0 at the matching output cycle; s and c SHALL hold their last valid values.
REQ-020 Overflow (a+b+cin >= 2^64) SHALL NOT be flagged separately; it is visible only as s[64]=1.

Reset
REQ-021 rst_n low SHALL immediately clear s, c, out_valid and every internal pipeline register to 0, independent of clk.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight operations; none SHALL emerge after release.
REQ-023 The first in_valid sampled on the first rising edge after rst_n rises SHALL be accepted normally.

Configuration
REQ-024 Macro KS64_PIPELINE_EN defined: a register stage SHALL be inserted after prefix level 3 (g/p groups, p vector and valid pipelined), latency 2 cycles from in_valid to out_valid.
REQ-025 KS64_PIPELINE_EN undefined: the prefix tree SHALL be purely combinational between input sampling and the output register, latency 1 cycle.
REQ-026 Arithmetic results SHALL be identical in both configurations; only latency differs.

Verification
REQ-027 a=0, b=0, cin=0, in_valid=1 -> s=65'h0, c=64'h0, out_valid=1 after latency.
REQ-028 a=64'h631ff211631ff211, b=64'h12356312faf2fcff, cin=0 -> s=65'h0_755555245E12EF10.
REQ-029 a=64'hffffffffffffffff, b=64'hffffffff11111111, cin=0 -> s=65'h1_FFFFFFFF11111110, c=64'hffffffffffffffff.
REQ-030 a=64'hffffffffffffffff, b=0, cin=1 -> s=65'h1_0000000000000000, c=all ones (full-width carry propagation through every prefix level).
REQ-031 Back-to-back in_valid for 4 cycles with distinct operands, then in_valid=0 -> 4 consecutive correct results then out_valid=0, s/c held; check latency 1 without macro, 2 with KS64_PIPELINE_EN.
REQ-032 Operation accepted, rst_n pulsed low before result emerges -> s, c, out_valid read 0 immediately during reset, and no result emerges after release.
